// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreakWait
    } rx_state_e;

    // Clocks per oversample tick, truncated.
    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        return clk_hz / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider; the receiver clears it on a start edge so the sample phase
// is aligned to that edge.
module uart_baud_tick #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: oversampled majority-vote bit decisions, parity and stop checks,
// break detection and a valid/ready character output.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter parity_e     PARITY     = PAR_NONE,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 uart_rxd,
    input  logic                 uart_rx_en,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 uart_rx_break,
    output logic                 err_frame,
    output logic                 err_parity,
    output logic                 err_overrun
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned SW  = $clog2(OVERSAMPLE);

    localparam logic [SW-1:0] S_LO      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID     = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_HI      = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END     = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (DIV == 0) begin : g_bad_div
        $error("uart_rx_cfg: CLK_HZ too low for BAUD * OVERSAMPLE");
    end
    if (OVERSAMPLE < 8) begin : g_bad_os
        $error("uart_rx_cfg: OVERSAMPLE must be at least 8");
    end

    logic [1:0] sync_q;
    logic       rxd_s;

    rx_state_e            state_q, state_d;
    logic [SW-1:0]        scnt_q, scnt_d;
    logic [1:0]           vote_q, vote_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 stop_ok_q, stop_ok_d;
    logic                 stop_first_q, stop_first_d;

    logic [DATA_BITS-1:0] m_data_q, m_data_d;
    logic                 m_valid_q, m_valid_d;
    logic                 brk_q, brk_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;

    logic tick, tick_clear;
    logic decide, bit_end, maj;
    logic frame_done;
    logic first_stop, stops_ok, exp_par, par_bad, is_break;

    assign rxd_s = sync_q[1];

    uart_baud_tick #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clear  (tick_clear),
        .tick   (tick)
    );

    assign decide  = tick && (scnt_q == S_HI);
    assign bit_end = tick && (scnt_q == S_END);
    assign maj     = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxd_s) | (vote_q[1] & rxd_s);

    // Frame verdict terms; the current majority stands in for a stop bit decided this cycle.
    assign first_stop = (stop_idx_q == 1'b0) ? maj : stop_first_q;
    assign stops_ok   = stop_ok_q & maj;
    assign exp_par    = (PARITY == PAR_ODD) ? ~(^shreg_q) : ^shreg_q;
    assign par_bad    = (PARITY != PAR_NONE) && (par_q != exp_par);
    assign is_break   = (shreg_q == '0) && ((PARITY == PAR_NONE) || !par_q) && !first_stop;

    always_comb begin
        state_d      = state_q;
        scnt_d       = scnt_q;
        vote_d       = vote_q;
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        par_d        = par_q;
        stop_idx_d   = stop_idx_q;
        stop_ok_d    = stop_ok_q;
        stop_first_d = stop_first_q;
        tick_clear   = 1'b0;
        frame_done   = 1'b0;

        if (tick) begin
            if (scnt_q == S_LO)  vote_d[0] = rxd_s;
            if (scnt_q == S_MID) vote_d[1] = rxd_s;
            scnt_d = bit_end ? '0 : scnt_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                scnt_d = '0;
                if (uart_rx_en && !rxd_s) begin
                    state_d    = StStart;
                    tick_clear = 1'b1;
                end
            end
            StStart: begin
                if (decide && maj) begin
                    state_d = StIdle;
                    scnt_d  = '0;
                end else if (bit_end) begin
                    state_d    = StData;
                    bitcnt_d   = '0;
                    stop_idx_d = 1'b0;
                    stop_ok_d  = 1'b1;
                end
            end
            StData: begin
                if (decide) shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                if (bit_end) begin
                    if (bitcnt_q == LAST_BIT) begin
                        state_d = (PARITY == PAR_NONE) ? StStop : StParity;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end
            StParity: begin
                if (decide) par_d = maj;
                if (bit_end) state_d = StStop;
            end
            StStop: begin
                // The last stop bit completes at its decision point, not its bit end.
                if (decide) begin
                    stop_ok_d = stop_ok_q & maj;
                    if (stop_idx_q == 1'b0) stop_first_d = maj;
                    if (stop_idx_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        state_d    = StIdle;
                        scnt_d     = '0;
                    end
                end else if (bit_end) begin
                    stop_idx_d = 1'b1;
                end
            end
            StBreakWait: begin
                if (tick) begin
                    if (!rxd_s) begin
                        scnt_d = '0;
                    end else if (bit_end) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (!uart_rx_en && (state_q != StIdle)) begin
            state_d    = StIdle;
            scnt_d     = '0;
            frame_done = 1'b0;
        end

        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_ready;
        brk_d     = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (frame_done) begin
            if (is_break) begin
                brk_d   = 1'b1;
                state_d = StBreakWait;
            end else if (!stops_ok) begin
                ferr_d = 1'b1;
            end else if (par_bad) begin
                perr_d = 1'b1;
            end else if (!m_valid_q || m_ready) begin
                m_data_d  = shreg_q;
                m_valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q       <= 2'b11;
            state_q      <= StIdle;
            scnt_q       <= '0;
            vote_q       <= '0;
            bitcnt_q     <= '0;
            shreg_q      <= '0;
            par_q        <= 1'b0;
            stop_idx_q   <= 1'b0;
            stop_ok_q    <= 1'b0;
            stop_first_q <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            brk_q        <= 1'b0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], uart_rxd};
            state_q      <= state_d;
            scnt_q       <= scnt_d;
            vote_q       <= vote_d;
            bitcnt_q     <= bitcnt_d;
            shreg_q      <= shreg_d;
            par_q        <= par_d;
            stop_idx_q   <= stop_idx_d;
            stop_ok_q    <= stop_ok_d;
            stop_first_q <= stop_first_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            brk_q        <= brk_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            ovr_q        <= ovr_d;
        end
    end

    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign uart_rx_break = brk_q;
    assign err_frame     = ferr_q;
    assign err_parity    = perr_q;
    assign err_overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clk per bit, table vectors,
// hand-written corner sequences and random frames checked against a frame-level model.
module tb_uart_rx_cfg;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;

    localparam logic [19:0] EV_X    = 20'h10000;
    localparam logic [19:0] EV_B    = 20'h01000;
    localparam logic [19:0] EV_F    = 20'h00100;
    localparam logic [19:0] EV_P    = 20'h00010;
    localparam logic [19:0] EV_O    = 20'h00001;
    localparam logic [19:0] EV_NONE = 20'h00000;

    logic clk, resetn;
    logic rxd[3], en[3], rdy[3];
    logic vld[3], brk[3], fe[3], pe[3], ov[3];
    logic [8:0] dat[3];
    logic [7:0] d0, d2;
    logic [6:0] d1;

    assign dat[0] = {1'b0, d0};
    assign dat[1] = {2'b00, d1};
    assign dat[2] = {1'b0, d2};

    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(PAR_NONE), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd[0]), .uart_rx_en(en[0]),
        .m_data(d0), .m_valid(vld[0]), .m_ready(rdy[0]), .uart_rx_break(brk[0]),
        .err_frame(fe[0]), .err_parity(pe[0]), .err_overrun(ov[0]));

    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(7),
                  .PARITY(PAR_EVEN), .STOP_BITS(1)) u_7e1 (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd[1]), .uart_rx_en(en[1]),
        .m_data(d1), .m_valid(vld[1]), .m_ready(rdy[1]), .uart_rx_break(brk[1]),
        .err_frame(fe[1]), .err_parity(pe[1]), .err_overrun(ov[1]));

    uart_rx_cfg #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
                  .PARITY(PAR_NONE), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .resetn(resetn), .uart_rxd(rxd[2]), .uart_rx_en(en[2]),
        .m_data(d2), .m_valid(vld[2]), .m_ready(rdy[2]), .uart_rx_break(brk[2]),
        .err_frame(fe[2]), .err_parity(pe[2]), .err_overrun(ov[2]));

    always #5 clk = ~clk;

    int n_tests, n_fail;
    int n_xfer[3], n_brk[3], n_fe[3], n_pe[3], n_ov[3];
    int s_xfer[3], s_brk[3], s_fe[3], s_pe[3], s_ov[3];
    logic [8:0] last_d[3];

    // Event monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (vld[k] && rdy[k]) begin
                n_xfer[k] = n_xfer[k] + 1;
                last_d[k] = dat[k];
            end
            if (brk[k]) n_brk[k] = n_brk[k] + 1;
            if (fe[k])  n_fe[k]  = n_fe[k] + 1;
            if (pe[k])  n_pe[k]  = n_pe[k] + 1;
            if (ov[k])  n_ov[k]  = n_ov[k] + 1;
        end
    end

    function automatic int cfg_db(input int k);
        return (k == 1) ? 7 : 8;
    endfunction

    function automatic parity_e cfg_par(input int k);
        return (k == 1) ? PAR_EVEN : PAR_NONE;
    endfunction

    function automatic int cfg_sb(input int k);
        return (k == 2) ? 2 : 1;
    endfunction

    // Frame-level reference: outcome of one complete frame with the output idle and ready.
    function automatic logic [28:0] model(input int k, input logic [8:0] d, input bit pbit,
                                          input bit [1:0] stops);
        bit has_par, exp_par, all_ok;
        has_par = (cfg_par(k) != PAR_NONE);
        exp_par = ($countones(d) % 2) == 1;
        if (cfg_par(k) == PAR_ODD) exp_par = !exp_par;
        all_ok = stops[0] && ((cfg_sb(k) == 1) || stops[1]);
        if (d == 9'd0 && (!has_par || !pbit) && !stops[0]) return {EV_B, 9'd0};
        if (!all_ok) return {EV_F, 9'd0};
        if (has_par && (pbit != exp_par)) return {EV_P, 9'd0};
        return {EV_X, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap(input int k);
        s_xfer[k] = n_xfer[k];
        s_brk[k]  = n_brk[k];
        s_fe[k]   = n_fe[k];
        s_pe[k]   = n_pe[k];
        s_ov[k]   = n_ov[k];
    endtask

    function automatic logic [19:0] ev(input int k);
        int x, b, f, p, o;
        x = n_xfer[k] - s_xfer[k];
        b = n_brk[k] - s_brk[k];
        f = n_fe[k] - s_fe[k];
        p = n_pe[k] - s_pe[k];
        o = n_ov[k] - s_ov[k];
        return {4'(x), 4'(b), 4'(f), 4'(p), 4'(o)};
    endfunction

    task automatic send_frame(input int k, input logic [8:0] d, input bit pbit,
                              input bit [1:0] stops);
        logic [15:0] bits;
        int n;
        bits = '0;
        n = 1;
        for (int i = 0; i < cfg_db(k); i++) begin
            bits[n] = d[i];
            n++;
        end
        if (cfg_par(k) != PAR_NONE) begin
            bits[n] = pbit;
            n++;
        end
        for (int i = 0; i < cfg_sb(k); i++) begin
            bits[n] = stops[i];
            n++;
        end
        for (int i = 0; i < n; i++) begin
            rxd[k] = bits[i];
            wait_clks(16);
        end
        rxd[k] = 1'b1;
        wait_clks(40);
    endtask

    task automatic run_frame(input string name, input int k, input logic [8:0] d,
                             input bit pbit, input bit [1:0] stops,
                             input logic [19:0] exp_ev, input logic [8:0] exp_d);
        snap(k);
        send_frame(k, d, pbit, stops);
        check({name, " events"}, 32'(ev(k)), 32'(exp_ev));
        if (exp_ev == EV_X) check({name, " data"}, 32'(last_d[k]), 32'(exp_d));
    endtask

    typedef struct {
        int         k;
        logic [8:0] d;
        bit         pbit;
        bit [1:0]   stops;
        logic [19:0] exp_ev;
        logic [8:0] exp_d;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [28:0] exp;
        logic [8:0]  d;
        bit          pbit;
        bit [1:0]    stops;
        int          k;

        n_tests = 0;
        n_fail  = 0;
        clk     = 1'b0;
        resetn  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rxd[i] = 1'b1; en[i] = 1'b1; rdy[i] = 1'b1;
            n_xfer[i] = 0; n_brk[i] = 0; n_fe[i] = 0; n_pe[i] = 0; n_ov[i] = 0;
            last_d[i] = '0;
        end

        tbl[0]  = '{0, 9'h0A5, 1'b0, 2'b11, EV_X, 9'h0A5};
        tbl[1]  = '{1, 9'h041, 1'b1, 2'b11, EV_P, 9'h000};
        tbl[2]  = '{1, 9'h041, 1'b0, 2'b11, EV_X, 9'h041};
        tbl[3]  = '{1, 9'h043, 1'b1, 2'b11, EV_X, 9'h043};
        tbl[4]  = '{1, 9'h043, 1'b0, 2'b11, EV_P, 9'h000};
        tbl[5]  = '{2, 9'h05A, 1'b0, 2'b01, EV_F, 9'h000};
        tbl[6]  = '{0, 9'h000, 1'b0, 2'b00, EV_B, 9'h000};
        tbl[7]  = '{0, 9'h0FF, 1'b0, 2'b00, EV_F, 9'h000};
        tbl[8]  = '{2, 9'h000, 1'b0, 2'b10, EV_B, 9'h000};
        tbl[9]  = '{2, 9'h080, 1'b0, 2'b10, EV_F, 9'h000};
        tbl[10] = '{1, 9'h000, 1'b1, 2'b00, EV_F, 9'h000};
        tbl[11] = '{2, 9'h03C, 1'b0, 2'b11, EV_X, 9'h03C};
        tbl[12] = '{1, 9'h07F, 1'b1, 2'b11, EV_X, 9'h07F};
        tbl[13] = '{0, 9'h000, 1'b0, 2'b11, EV_X, 9'h000};

        wait_clks(3);
        for (int i = 0; i < 3; i++)
            check($sformatf("reset outputs u%0d", i),
                  32'({vld[i], brk[i], fe[i], pe[i], ov[i], dat[i]}), 32'd0);
        resetn = 1'b1;
        wait_clks(20);

        for (int i = 0; i < 14; i++)
            run_frame($sformatf("vec%0d", i), tbl[i].k, tbl[i].d, tbl[i].pbit, tbl[i].stops,
                      tbl[i].exp_ev, tbl[i].exp_d);

        // Break on 8N2: long low, short high, low again, then a normal byte.
        snap(2);
        rxd[2] = 1'b0;
        wait_clks(192);
        rxd[2] = 1'b1;
        wait_clks(8);
        check("break pulse", 32'(ev(2)), 32'(EV_B));
        rxd[2] = 1'b0;
        wait_clks(20);
        rxd[2] = 1'b1;
        wait_clks(40);
        check("break wait holds", 32'(ev(2)), 32'(EV_B));
        run_frame("after break", 2, 9'h03C, 1'b0, 2'b11, EV_X, 9'h03C);

        // Overrun on 8N1 with the consumer stalled.
        rdy[0] = 1'b0;
        run_frame("ovr first", 0, 9'h011, 1'b0, 2'b11, EV_NONE, 9'h000);
        check("ovr first held", 32'({vld[0], dat[0]}), 32'({1'b1, 9'h011}));
        run_frame("ovr second", 0, 9'h022, 1'b0, 2'b11, EV_O, 9'h000);
        check("ovr data kept", 32'({vld[0], dat[0]}), 32'({1'b1, 9'h011}));
        snap(0);
        rdy[0] = 1'b1;
        wait_clks(1);
        check("ovr drain valid", 32'(vld[0]), 32'd0);
        check("ovr drain events", 32'(ev(0)), 32'(EV_X));
        check("ovr drain data", 32'(last_d[0]), 32'h011);

        // Short idle glitch must be rejected.
        snap(0);
        rxd[0] = 1'b0;
        wait_clks(4);
        rxd[0] = 1'b1;
        wait_clks(40);
        check("glitch", 32'(ev(0)), 32'(EV_NONE));

        // Enable dropped mid-frame.
        snap(0);
        fork
            send_frame(0, 9'h055, 1'b0, 2'b11);
            begin
                wait_clks(70);
                en[0] = 1'b0;
                wait_clks(120);
                en[0] = 1'b1;
            end
        join
        check("enable abort", 32'(ev(0)), 32'(EV_NONE));
        run_frame("after abort", 0, 9'h0B7, 1'b0, 2'b11, EV_X, 9'h0B7);

        // Random frames against the model.
        for (int i = 0; i < 30; i++) begin
            k = $urandom_range(0, 2);
            d = 9'($urandom) & 9'((1 << cfg_db(k)) - 1);
            if ($urandom_range(0, 7) == 0) d = '0;
            pbit = 1'($urandom);
            stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            exp = model(k, d, pbit, stops);
            run_frame($sformatf("rand%0d u%0d d=%h p=%0d s=%b", i, k, d, pbit, stops),
                      k, d, pbit, stops, exp[28:9], exp[8:0]);
        end

        // Reset during DATA with a character held.
        rdy[0] = 1'b0;
        run_frame("pre-reset hold", 0, 9'h05A, 1'b0, 2'b11, EV_NONE, 9'h000);
        check("pre-reset valid", 32'({vld[0], dat[0]}), 32'({1'b1, 9'h05A}));
        snap(0);
        fork
            send_frame(0, 9'h0E1, 1'b0, 2'b11);
            begin
                wait_clks(60);
                resetn = 1'b0;
                wait_clks(1);
                check("reset mid frame",
                      32'({vld[0], brk[0], fe[0], pe[0], ov[0], dat[0]}), 32'd0);
                wait_clks(120);
                resetn = 1'b1;
            end
        join
        check("reset no events", 32'(ev(0)), 32'(EV_NONE));
        rdy[0] = 1'b1;
        run_frame("after reset", 0, 9'h0C3, 1'b0, 2'b11, EV_X, 9'h0C3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
